// File: rtl/seg7_display_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_display_driver
// Brief    : Scans packed BCD digits onto NUM_DIGITS seven-segment displays,
//            one digit per refresh_tick, with pause blinking.
//            Optional build macro: LEADING_ZERO_BLANK_EN (blank leading zeros).
// Revision : 1.0 - initial release
// ============================================================================
module seg7_display_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int BLINK_DIV  = 500,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    refresh_tick,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    paused,
    output logic                    busy,
    output logic                    done,
    output logic [7*NUM_DIGITS-1:0] hex_out
);

    localparam int c_idx_w = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int c_cnt_w = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_DIGITS - 1);
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(BLINK_DIV - 1);
    localparam logic [6:0] c_inv = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [7*NUM_DIGITS-1:0] c_all_dark = {NUM_DIGITS{c_inv}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                         r_state;
    state_t                         w_state_next;

    logic [NUM_DIGITS-1:0][3:0]     r_shadow_digits;
    logic [NUM_DIGITS-1:0]          r_shadow_blank;
    logic [NUM_DIGITS-1:0][3:0]     r_pend_digits;
    logic [NUM_DIGITS-1:0]          r_pend_blank;
    logic                           r_pend_valid;
    logic [c_idx_w-1:0]             r_index;
    logic [NUM_DIGITS-1:0][6:0]     r_seg;
    logic [c_cnt_w-1:0]             r_blink_cnt;
    logic                           r_phase;
    logic [7*NUM_DIGITS-1:0]        r_hex;

    logic                           w_shadow_from_in;
    logic                           w_shadow_from_pend;
    logic                           w_pend_wr;
    logic                           w_pend_clr;
    logic                           w_seg_wr;
    logic [NUM_DIGITS-1:0]          w_cap_blank;
    logic [6:0]                     w_seg_new;

    // Blanking captured alongside the digits; leading-zero rule optional.
`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0]          w_lz_blank;

    always_comb begin : p_lz_blank
        logic w_run;
        w_lz_blank = '0;
        w_run      = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (w_run && (digits_in[4*i +: 4] == 4'd0)) begin
                w_lz_blank[i] = 1'b1;
            end else begin
                w_run = 1'b0;
            end
        end
    end

    assign w_cap_blank = blank_mask | w_lz_blank;
`else
    assign w_cap_blank = blank_mask;
`endif

    // Lit pattern with bit0 = a .. bit6 = g, before polarity is applied.
    function automatic logic [6:0] seg_lit(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h40;
        endcase
        return p;
    endfunction

    assign w_seg_new = (r_shadow_blank[r_index] ? 7'h00
                                                : seg_lit(r_shadow_digits[r_index])) ^ c_inv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A load landing in DONE with nothing pending is parked and picked up from IDLE.
    always_comb begin
        w_state_next       = r_state;
        w_shadow_from_in   = 1'b0;
        w_shadow_from_pend = 1'b0;
        w_pend_wr          = 1'b0;
        w_pend_clr         = 1'b0;
        w_seg_wr           = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pend_valid) begin
                    w_shadow_from_pend = 1'b1;
                    w_pend_clr         = 1'b1;
                    w_pend_wr          = load;
                    w_state_next       = S_SCAN;
                end else if (load) begin
                    w_shadow_from_in = 1'b1;
                    w_state_next     = S_SCAN;
                end
            end
            S_SCAN: begin
                w_pend_wr = load;
                if (refresh_tick) begin
                    w_seg_wr = 1'b1;
                    if (r_index == c_last_idx) begin
                        w_state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_pend_wr = load;
                if (r_pend_valid) begin
                    w_shadow_from_pend = 1'b1;
                    w_pend_clr         = 1'b1;
                    w_state_next       = S_SCAN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow_digits <= '0;
            r_shadow_blank  <= '0;
            r_index         <= '0;
        end else if (w_shadow_from_in) begin
            r_shadow_digits <= digits_in;
            r_shadow_blank  <= w_cap_blank;
            r_index         <= '0;
        end else if (w_shadow_from_pend) begin
            r_shadow_digits <= r_pend_digits;
            r_shadow_blank  <= r_pend_blank;
            r_index         <= '0;
        end else if (w_seg_wr) begin
            r_index <= r_index + 1'b1;
        end
    end

    // A new load outranks the clear so a back-to-back load is never dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_digits <= '0;
            r_pend_blank  <= '0;
            r_pend_valid  <= 1'b0;
        end else if (w_pend_wr) begin
            r_pend_digits <= digits_in;
            r_pend_blank  <= w_cap_blank;
            r_pend_valid  <= 1'b1;
        end else if (w_pend_clr) begin
            r_pend_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg <= c_all_dark;
        end else if (w_seg_wr) begin
            r_seg[r_index] <= w_seg_new;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (!paused) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (refresh_tick) begin
            if (r_blink_cnt == c_last_cnt) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    // Blink masks only the output register; the scanned segments stay intact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hex <= c_all_dark;
        end else if (paused && r_phase) begin
            r_hex <= c_all_dark;
        end else begin
            r_hex <= r_seg;
        end
    end

    assign hex_out = r_hex;

endmodule
`default_nettype wire

// File: tb/tb_seg7_display_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_display_driver
// Brief    : Self-checking bench for seg7_display_driver (4 digits, active-low,
//            BLINK_DIV = 2). Honours LEADING_ZERO_BLANK_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_display_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        refresh_tick;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  blank_mask;
    logic        paused;
    logic        busy;
    logic        done;
    logic [27:0] hex_out;

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;

    seg7_display_driver #(
        .NUM_DIGITS (4),
        .BLINK_DIV  (2),
        .ACTIVE_LOW (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .refresh_tick (refresh_tick),
        .load         (load),
        .digits_in    (digits_in),
        .blank_mask   (blank_mask),
        .paused       (paused),
        .busy         (busy),
        .done         (done),
        .hex_out      (hex_out)
    );

    always #5 clk = ~clk;

    // Active-low glyphs straight from the display's segment map.
    function automatic logic [6:0] enc(input logic [3:0] d, input logic bl);
        if (bl) return 7'h7F;
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    function automatic logic [3:0] cap_blank(input logic [15:0] w, input logic [3:0] m);
        logic [3:0] b;
`ifdef LEADING_ZERO_BLANK_EN
        int i;
`endif
        b = m;
`ifdef LEADING_ZERO_BLANK_EN
        i = 3;
        while (i > 0 && w[4*i +: 4] == 4'd0) begin
            b[i] = 1'b1;
            i--;
        end
`endif
        return b;
    endfunction

    // Reference model: mode 0 idle, 1 scanning, 2 finished-this-cycle.
    int          m_mode;
    int          m_pos;
    logic [15:0] m_sh_word;
    logic [3:0]  m_sh_blank;
    bit          m_pend_v;
    logic [15:0] m_pend_word;
    logic [3:0]  m_pend_blank;
    logic [6:0]  m_seg [4];
    logic [27:0] m_hex;
    int          m_cnt;
    bit          m_ph;
    logic [27:0] m_nh;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_mode = 0; m_pos = 0; m_sh_word = '0; m_sh_blank = '0;
                m_pend_v = 0; m_pend_word = '0; m_pend_blank = '0;
                for (int k = 0; k < 4; k++) m_seg[k] = 7'h7F;
                m_hex = 28'hFFFFFFF; m_cnt = 0; m_ph = 0;
            end else begin
                m_nh = (paused && m_ph) ? 28'hFFFFFFF : {m_seg[3], m_seg[2], m_seg[1], m_seg[0]};
                if (!paused) begin
                    m_cnt = 0; m_ph = 0;
                end else if (refresh_tick) begin
                    m_cnt = (m_cnt + 1) % 2;
                    if (m_cnt == 0) m_ph = ~m_ph;
                end
                case (m_mode)
                    0: begin
                        if (m_pend_v) begin
                            m_sh_word = m_pend_word; m_sh_blank = m_pend_blank;
                            m_pend_v = load;
                            if (load) begin m_pend_word = digits_in; m_pend_blank = cap_blank(digits_in, blank_mask); end
                            m_mode = 1; m_pos = 0;
                        end else if (load) begin
                            m_sh_word = digits_in; m_sh_blank = cap_blank(digits_in, blank_mask);
                            m_mode = 1; m_pos = 0;
                        end
                    end
                    1: begin
                        if (load) begin
                            m_pend_v = 1; m_pend_word = digits_in; m_pend_blank = cap_blank(digits_in, blank_mask);
                        end
                        if (refresh_tick) begin
                            m_seg[m_pos] = enc(m_sh_word[4*m_pos +: 4], m_sh_blank[m_pos]);
                            m_pos++;
                            if (m_pos == 4) m_mode = 2;
                        end
                    end
                    default: begin
                        if (m_pend_v) begin
                            m_sh_word = m_pend_word; m_sh_blank = m_pend_blank;
                            m_pend_v = 0; m_mode = 1; m_pos = 0;
                        end else begin
                            m_mode = 0;
                        end
                        if (load) begin
                            m_pend_v = 1; m_pend_word = digits_in; m_pend_blank = cap_blank(digits_in, blank_mask);
                        end
                    end
                endcase
                m_hex = m_nh;
            end
        end
    end

    task automatic chk(input string nm, input logic [27:0] act, input logic [27:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("model hex_out", hex_out, m_hex);
                chk("model busy", {27'd0, busy}, {27'd0, m_mode != 0});
                chk("model done", {27'd0, done}, {27'd0, m_mode == 2});
                if (done === 1'b1) n_done++;
            end
        end
    end

    task automatic cyc(input logic t, input logic l, input logic [15:0] d, input logic [3:0] m);
        refresh_tick = t;
        load         = l;
        digits_in    = d;
        blank_mask   = m;
        @(posedge clk);
        #1;
        refresh_tick = 1'b0;
        load         = 1'b0;
    endtask

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [27:0] c_exp_0059 = {7'h7F, 7'h7F, 7'h12, 7'h10};
    localparam logic [27:0] c_exp_0000 = {7'h7F, 7'h7F, 7'h7F, 7'h40};
`else
    localparam logic [27:0] c_exp_0059 = {7'h40, 7'h40, 7'h12, 7'h10};
    localparam logic [27:0] c_exp_0000 = {7'h40, 7'h40, 7'h40, 7'h40};
`endif

    initial begin
        rst = 1'b1; refresh_tick = 0; load = 0; digits_in = '0; blank_mask = '0; paused = 0;
        @(posedge clk);
        #1;
        chk("reset hex_out", hex_out, 28'hFFFFFFF);
        chk("reset busy", {27'd0, busy}, 28'd0);
        chk("reset done", {27'd0, done}, 28'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(0, 0, '0, '0);

        // Basic scan of 1234
        cyc(0, 1, 16'h1234, 4'b0000);
        chk("busy after load", {27'd0, busy}, 28'd1);
        for (int k = 0; k < 4; k++) cyc(1, 0, '0, '0);
        chk("done after 4th tick", {27'd0, done}, 28'd1);
        cyc(0, 0, '0, '0);
        chk("hex 1234", hex_out, {7'h79, 7'h24, 7'h30, 7'h19});
        chk("busy falls", {27'd0, busy}, 28'd0);
        chk("done count 1", 28'(n_done), 28'd1);

        // Load during a scan queues the next word
        cyc(0, 1, 16'h1234, 4'b0000);
        cyc(1, 0, '0, '0);
        cyc(0, 1, 16'h0059, 4'b0000);
        for (int k = 0; k < 3; k++) cyc(1, 0, '0, '0);
        cyc(0, 0, '0, '0);
        for (int k = 0; k < 4; k++) cyc(1, 0, '0, '0);
        cyc(0, 0, '0, '0);
        cyc(0, 0, '0, '0);
        chk("hex 0059", hex_out, c_exp_0059);
        chk("done count 3", 28'(n_done), 28'd3);

        // Blink while paused
        paused = 1'b1;
        cyc(0, 0, '0, '0);
        for (int k = 1; k <= 6; k++) begin
            cyc(1, 0, '0, '0);
            cyc(0, 0, '0, '0);
            if (k == 2) chk("blink dark", hex_out, 28'hFFFFFFF);
            if (k == 4) chk("blink restored", hex_out, c_exp_0059);
        end
        paused = 1'b0;
        cyc(0, 0, '0, '0);
        chk("unpause restored", hex_out, c_exp_0059);

        // Dash and blank mask
        cyc(0, 1, 16'h57A1, 4'b0100);
        for (int k = 0; k < 4; k++) cyc(1, 0, '0, '0);
        cyc(0, 0, '0, '0);
        cyc(0, 0, '0, '0);
        chk("hex dash/blank", hex_out, {7'h12, 7'h7F, 7'h3F, 7'h79});

        // Asynchronous reset mid-scan
        cyc(0, 1, 16'h1234, 4'b0000);
        cyc(1, 0, '0, '0);
        cyc(1, 0, '0, '0);
        #2 rst = 1'b1;
        #1;
        chk("async rst hex_out", hex_out, 28'hFFFFFFF);
        chk("async rst busy", {27'd0, busy}, 28'd0);
        chk("async rst done", {27'd0, done}, 28'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(0, 0, '0, '0);

        // All-zero word
        cyc(0, 1, 16'h0000, 4'b0000);
        for (int k = 0; k < 4; k++) cyc(1, 0, '0, '0);
        cyc(0, 0, '0, '0);
        cyc(0, 0, '0, '0);
        chk("hex 0000", hex_out, c_exp_0000);

        repeat (2) cyc(0, 0, '0, '0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
